// File: rtl/seq_divider.sv
// Radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// It borrows an external carry look-ahead adder for every trial subtraction and for the final sign fix-up.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout
);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIXQ,
        FIXR,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q_q, neg_r_q, div_zero_q;

    logic             dvd_neg_d, dsr_neg_d;
    logic [WIDTH-1:0] abs_dvd_d, abs_dsr_d;
    logic [WIDTH-1:0] shift_d;
    logic             qbit_d;
    logic             accept_d;
    logic             overflow_d;
    logic             last_iter_d;

    // Operand magnitudes use a private negate so the shared adder stays free at acceptance.
    assign dvd_neg_d   = is_signed & dividend[WIDTH-1];
    assign dsr_neg_d   = is_signed & divisor[WIDTH-1];
    assign abs_dvd_d   = dvd_neg_d ? (~dividend + WIDTH'(1)) : dividend;
    assign abs_dsr_d   = dsr_neg_d ? (~divisor + WIDTH'(1)) : divisor;
    assign overflow_d  = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

    assign shift_d     = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    assign qbit_d      = r_q[WIDTH-1] | add_cout;
    assign last_iter_d = (cnt_q == CNT_W'(WIDTH-1));

    assign ready       = (state_q == IDLE) || (state_q == DONE);
    assign done        = (state_q == DONE);
    assign accept_d    = start & ready;

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_zero    = div_zero_q;

    always_comb begin
        add_a    = '0;
        add_b    = '0;
        add_mode = 1'b0;
        add_cin  = 1'b0;
        case (state_q)
            CALC: begin
                add_a    = shift_d;
                add_b    = d_q;
                add_mode = 1'b1;
                add_cin  = 1'b1;
            end
            FIXQ: begin
                add_b    = q_q;
                add_mode = 1'b1;
                add_cin  = 1'b1;
            end
            FIXR: begin
                add_b    = r_q;
                add_mode = 1'b1;
                add_cin  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_d) begin
                        r_q     <= '0;
                        q_q     <= abs_dvd_d;
                        d_q     <= abs_dsr_d;
                        cnt_q   <= '0;
                        neg_q_q <= dvd_neg_d ^ dsr_neg_d;
                        neg_r_q <= dvd_neg_d;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            div_zero_q  <= 1'b1;
                            state_q     <= DONE;
                        end else if (overflow_d) begin
                            quotient_q  <= dividend;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b0;
                            state_q     <= DONE;
                        end else begin
                            div_zero_q  <= 1'b0;
                            state_q     <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    r_q   <= qbit_d ? add_sum : shift_d;
                    q_q   <= {q_q[WIDTH-2:0], qbit_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter_d) begin
                        state_q <= FIXQ;
                    end
                end
                FIXQ: begin
                    quotient_q <= neg_q_q ? add_sum : q_q;
                    state_q    <= FIXR;
                end
                FIXR: begin
                    remainder_q <= neg_r_q ? add_sum : r_q;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: models the external adder and scores each division against a queue of expected results.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend, divisor;
    logic         ready, done, div_zero;
    logic [W-1:0] quotient, remainder;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_mode, add_cout;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the carry look-ahead adder.
    logic [W:0] add_full;
    assign add_full = {1'b0, add_a} + {1'b0, (add_mode ? ~add_b : add_b)} + {{W{1'b0}}, add_cin};
    assign add_sum  = add_full[W-1:0];
    assign add_cout = add_full[W];

    seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
        .div_zero(div_zero),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_mode(add_mode),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.dz  = 1'b0;
        e.lat = 35;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a; e.r = '0; e.lat = 1;
        end else if (s) begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Caller is away from a clock edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz, input int elat);
        exp_t e;
        e.q = eq; e.r = er; e.dz = edz; e.lat = elat;
        sb.push_back(e);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int first, output int lat);
        @(negedge clk);
        lat = first;
        while (done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared += 6;
        if (ready !== 1'b1)   begin mismatched++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        if (done !== 1'b0)    begin mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        if (quotient !== '0)  begin mismatched++; $display("[TB] FAIL reset_quotient got %h want 0", quotient); end
        if (remainder !== '0) begin mismatched++; $display("[TB] FAIL reset_remainder got %h want 0", remainder); end
        if (div_zero !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_divzero got %b want 0", div_zero); end
        if ({add_a, add_b, add_mode, add_cin} !== '0)
            begin mismatched++; $display("[TB] FAIL reset_adder_idle got %h/%h/%b/%b want 0", add_a, add_b, add_mode, add_cin); end
    endtask

    task automatic test_unsigned;
        exp_t e;
        int   lat;
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        wait_done(1, lat);
        e = sb.pop_front();
        compared += 6;
        if (lat !== e.lat)       begin mismatched++; $display("[TB] FAIL udiv_latency got %0d want %0d", lat, e.lat); end
        if (quotient !== e.q)    begin mismatched++; $display("[TB] FAIL udiv_quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r)   begin mismatched++; $display("[TB] FAIL udiv_remainder got %h want %h", remainder, e.r); end
        if (div_zero !== e.dz)   begin mismatched++; $display("[TB] FAIL udiv_divzero got %b want %b", div_zero, e.dz); end
        @(negedge clk);
        if (done !== 1'b0)       begin mismatched++; $display("[TB] FAIL udiv_single_pulse got %b want 0", done); end
        if (quotient !== 32'd14) begin mismatched++; $display("[TB] FAIL udiv_hold got %h want 0000000e", quotient); end
    endtask

    // Signed cases, division by zero, overflow and full-width unsigned operands.
    task automatic test_special;
        logic         s_t[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [W-1:0] a_t[6]  = '{32'hFFFF_FFF9, 32'd7, 32'h1234_5678, 32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] b_t[6]  = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic [W-1:0] q_t[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] r_t[6]  = '{32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'hFFFF_FFFB, 32'd0, 32'd0};
        logic         dz_t[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int           l_t[6]  = '{35, 35, 1, 1, 1, 35};
        exp_t e;
        int   lat;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            issue(s_t[i], a_t[i], b_t[i], q_t[i], r_t[i], dz_t[i], l_t[i]);
            wait_done(1, lat);
            e = sb.pop_front();
            compared += 4;
            if (lat !== e.lat)     begin mismatched++; $display("[TB] FAIL special%0d_latency got %0d want %0d", i, lat, e.lat); end
            if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL special%0d_quotient got %h want %h", i, quotient, e.q); end
            if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL special%0d_remainder got %h want %h", i, remainder, e.r); end
            if (div_zero !== e.dz) begin mismatched++; $display("[TB] FAIL special%0d_divzero got %b want %b", i, div_zero, e.dz); end
        end
    endtask

    task automatic test_mid_calc_start;
        exp_t e;
        int   lat;
        @(negedge clk);
        issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 35);
        repeat (5) @(negedge clk);
        compared++;
        if (ready !== 1'b0) begin mismatched++; $display("[TB] FAIL midcalc_ready got %b want 0", ready); end
        start = 1'b1; is_signed = 1'b1; dividend = 32'd77; divisor = 32'd5;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(9, lat);
        e = sb.pop_front();
        compared += 3;
        if (lat !== e.lat)     begin mismatched++; $display("[TB] FAIL midcalc_latency got %0d want %0d", lat, e.lat); end
        if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL midcalc_quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL midcalc_remainder got %h want %h", remainder, e.r); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        @(negedge clk);
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 35);
        wait_done(1, lat);
        e = sb.pop_front();
        compared += 2;
        if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL b2b_first_quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL b2b_first_remainder got %h want %h", remainder, e.r); end
        issue(1'b1, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0, 35);
        wait_done(1, lat);
        e = sb.pop_front();
        compared += 3;
        if (lat !== e.lat)     begin mismatched++; $display("[TB] FAIL b2b_second_latency got %0d want %0d", lat, e.lat); end
        if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL b2b_second_quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL b2b_second_remainder got %h want %h", remainder, e.r); end
        repeat (3) @(negedge clk);
        compared += 2;
        if (ready !== 1'b1)           begin mismatched++; $display("[TB] FAIL b2b_idle_ready got %b want 1", ready); end
        if (quotient !== 32'hFFFF_FFF5) begin mismatched++; $display("[TB] FAIL b2b_hold got %h want fffffff5", quotient); end
    endtask

    task automatic test_reset_abort;
        exp_t e;
        int   lat;
        @(negedge clk);
        issue(1'b0, 32'hDEAD_BEEF, 32'd3, '0, '0, 1'b0, 35);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        compared += 5;
        if (ready !== 1'b1)    begin mismatched++; $display("[TB] FAIL abort_ready got %b want 1", ready); end
        if (done !== 1'b0)     begin mismatched++; $display("[TB] FAIL abort_done got %b want 0", done); end
        if (quotient !== '0)   begin mismatched++; $display("[TB] FAIL abort_quotient got %h want 0", quotient); end
        if (remainder !== '0)  begin mismatched++; $display("[TB] FAIL abort_remainder got %h want 0", remainder); end
        if (add_a !== '0)      begin mismatched++; $display("[TB] FAIL abort_adder got %h want 0", add_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 35);
        wait_done(1, lat);
        e = sb.pop_front();
        compared += 3;
        if (lat !== e.lat)     begin mismatched++; $display("[TB] FAIL after_abort_latency got %0d want %0d", lat, e.lat); end
        if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL after_abort_quotient got %h want %h", quotient, e.q); end
        if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL after_abort_remainder got %h want %h", remainder, e.r); end
    endtask

    task automatic test_random;
        exp_t         m, e;
        logic         s;
        logic [W-1:0] a, b;
        int           lat;
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            m = model(s, a, b);
            @(negedge clk);
            issue(s, a, b, m.q, m.r, m.dz, m.lat);
            wait_done(1, lat);
            e = sb.pop_front();
            compared += 3;
            if (lat !== e.lat)     begin mismatched++; $display("[TB] FAIL rand%0d_latency got %0d want %0d", i, lat, e.lat); end
            if (quotient !== e.q)  begin mismatched++; $display("[TB] FAIL rand%0d_quotient s=%b %h/%h got %h want %h", i, s, a, b, quotient, e.q); end
            if (remainder !== e.r) begin mismatched++; $display("[TB] FAIL rand%0d_remainder s=%b %h/%h got %h want %h", i, s, a, b, remainder, e.r); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout want completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_special();
        test_mid_calc_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
